seg_scan_decoder: RTL and testbench
===================================

Name: seg_scan_decoder

Overview:
Receive side of the team's multiplexed 8-digit, 7-segment display bus. Watches the active-low SEG/AN lines driven by a display scanner and rebuilds the 8 hex digit values and decimal points. Used as a loopback checker and display monitor in lab designs. A digit is committed only after its pattern has been stable for a set number of cycles, so glitches and scan transitions are filtered out.

Parameters:
STABLE_CYCLES, 4, consecutive identical samples required before commit (>=1, counter width $clog2(STABLE_CYCLES+1))
STALE_CYCLES, 100_000_000, refresh timeout per digit; used only with SEG_STALE_EN

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
seg_in  in  8  segment lines, active low; bit7=dp, bits6..0=g..a
an_in  in  8  anode selects, active low; bit i = digit i
digits  out  32  digit i code at [4i+3:4i]
dig_valid  out  8  bit i = digit i holds a decoded hex value
dp  out  8  bit i = 1 when the decimal point of digit i was lit
upd  out  1  one-cycle pulse on each committed hex or blank digit
upd_pos  out  3  position of the last commit
err_pattern  out  1  one-cycle pulse: unknown segment pattern
err_multi_an  out  1  one-cycle pulse: more than one anode low

Behaviour:
- Reset: digits=0, dig_valid=0, dp=0, upd=0, upd_pos=0, err_*=0; in_q (16b sample reg)=16'hFFFF, cnt=0, state=SETTLE.
- Every edge: in_q<={seg_in,an_in}. If the new sample differs from in_q: cnt<=0, state<=SETTLE. Otherwise cnt increments and saturates at STABLE_CYCLES.
- Commit edge: the edge where cnt goes STABLE_CYCLES-1 -> STABLE_CYCLES; state<=HOLD. Outputs change on this edge.
- Latency: an input change first applied before edge e1 is committed at edge e(1+STABLE_CYCLES), which is 5 edges for the default. Exactly one commit per stable period; HOLD makes no further commits until the input changes.
- Commit decode, all on the commit edge:
  - an all high: no action.
  - More than one anode low: err_multi_an=1; no storage change.
  - Exactly one anode low, pos=its index, upd_pos<=pos:
    - seg[6:0] in hex table: digits[pos]<=code, dig_valid[pos]<=1, dp[pos]<=~seg[7], upd=1.
    - seg[6:0]=7'h7F (blank): dig_valid[pos]<=0, dp[pos]<=~seg[7], upd=1, no error.
    - Any other pattern: err_pattern=1, dig_valid[pos]<=0, digits[pos] unchanged, upd=0.
- Hex table, seg[6:0] for 0..F: 40,79,24,30,19,12,02,78,00,18,08,03,46,21,06,0E. Lookup ignores bit7.
- upd and err_* are high for exactly one cycle per commit.
- Reset mid-settle discards the partial count. An input held through reset is committed STABLE_CYCLES+1 edges after reset deasserts.

Optional Feature:
SEG_STALE_EN
- Defined: per-digit age counter, cleared on any commit to that position and incremented otherwise (saturating). At STALE_CYCLES, dig_valid[i]<=0; digits and dp are kept.
- Undefined: no age counters; dig_valid changes only on commit or reset.

Decomposition:
- Package seg_scan_pkg holds:
  - the 16-entry 7-bit hex pattern array,
  - SEG_BLANK=7'h7F,
  - state enum {SETTLE, HOLD}.
- One combinational sub-module, seg_pattern_lookup: takes seg[6:0] and returns code[3:0], hit, blank.
- The stability FSM and digit storage stay in the top block.

Test Plan:
1. Reset; seg=C0, an=FE held 10 cycles -> at edge 5: digits[3:0]=0, dig_valid=01, upd one pulse with upd_pos=0; no second pulse.
2. Scan an=FE,FD,...,7F with patterns for 1..8, 8 cycles each -> digits=32'h87654321, dig_valid=FF, 8 upd pulses.
3. Glitch: seg=A4, an=FE held 3 cycles, then an=FF -> no upd, dig_valid stays 00.
4. an=FC, seg=A4 held -> one err_multi_an pulse, outputs unchanged. Then an=FE, seg=BF -> one err_pattern pulse, dig_valid[0]=0.
5. seg=00, an=F7 -> digits[15:12]=8, dp=08. Then seg=FF, an=F7 -> dig_valid[3]=0, dp[3]=0, upd pulse, no error.
6. Assert rst at cnt=2 while the input is held -> outputs cleared, commit 5 edges after release. With SEG_STALE_EN and STALE_CYCLES=20, stop refreshing digit 0 -> dig_valid[0] clears after 20 cycles.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared definitions for the 7-segment scan decoder.
//   HEX_PAT   : seg[6:0] patterns (active low, g..a) for hex digits 0..F
//   SEG_BLANK : all segments dark
//   scan_state_e : stability FSM states
package seg_scan_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [6:0] HEX_PAT [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   typedef enum logic {
      SETTLE = 1'b0,
      HOLD   = 1'b1
   } scan_state_e;

endpackage

// File: rtl/seg_scan_decoder_lookup.sv
// seg_pattern_lookup: combinational reverse lookup of a 7-segment pattern.
//   seg   in  7  segment pattern, active low, bits 6..0 = g..a
//   code  out 4  hex value of the pattern (0 when not a hex pattern)
//   hit   out 1  pattern is one of the 16 hex glyphs
//   blank out 1  pattern has every segment dark
module seg_pattern_lookup
   import seg_scan_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] code,
   output logic       hit,
   output logic       blank
);

   always_comb begin
      code = '0;
      hit  = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (seg == HEX_PAT[i]) begin
            code = 4'(i);
            hit  = 1'b1;
         end
      end
   end

   assign blank = (seg == SEG_BLANK);

endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: rebuilds 8 hex digits + decimal points from a multiplexed
// active-low 7-segment scan bus. A {seg,an} sample is committed once it has
// been stable for STABLE_CYCLES consecutive edges after a change.
//   clk, rst      clock, synchronous active-high reset
//   seg_in[7:0]   segments, active low, bit7 = dp, bits6..0 = g..a
//   an_in[7:0]    anode selects, active low, bit i = digit i
//   digits[31:0]  digit i code at [4i+3:4i]
//   dig_valid[7:0], dp[7:0]  per-digit valid / decimal point lit
//   upd, upd_pos  commit pulse for hex/blank digit, position of last commit
//   err_pattern, err_multi_an  one-cycle error pulses
// Optional build macro SEG_STALE_EN: per-digit age counters that drop
// dig_valid after STALE_CYCLES edges without a commit to that digit.
//
// state  | meaning
// SETTLE | sample changed recently, counting identical samples
// HOLD   | current sample already committed, wait for a change
module seg_scan_decoder
   import seg_scan_pkg::*;
#(
   parameter int STABLE_CYCLES = 4,
   parameter int STALE_CYCLES  = 100_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  seg_in,
   input  logic [7:0]  an_in,
   output logic [31:0] digits,
   output logic [7:0]  dig_valid,
   output logic [7:0]  dp,
   output logic        upd,
   output logic [2:0]  upd_pos,
   output logic        err_pattern,
   output logic        err_multi_an
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);

   if (STABLE_CYCLES < 1 || STALE_CYCLES < 1) begin : g_bad_params
      $error("seg_scan_decoder: STABLE_CYCLES and STALE_CYCLES must be >= 1");
   end

   logic [15:0]   in_q, in_d;
   logic [CW-1:0] cnt_q, cnt_d;
   scan_state_e   state_q, state_d;
   logic          commit;

   logic [7:0][3:0] digits_q, digits_d;
   logic [7:0]      valid_q, valid_d;
   logic [7:0]      dp_q, dp_d;
   logic            upd_q, upd_d;
   logic [2:0]      upd_pos_q, upd_pos_d;
   logic            err_pattern_q, err_pattern_d;
   logic            err_multi_q, err_multi_d;

   logic [7:0] an_low;
   logic       any_low, one_hot;
   logic [2:0] pos;
   logic [3:0] code;
   logic       hit, blank;

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         in_q    <= 16'hFFFF;
         cnt_q   <= '0;
         state_q <= SETTLE;
      end else begin
         in_q    <= in_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
      end
   end

   // next state: the count restarts on any sample change and saturates, so
   // the STABLE_CYCLES-1 -> STABLE_CYCLES step happens once per stable period
   always_comb begin
      in_d    = {seg_in, an_in};
      cnt_d   = cnt_q;
      state_d = state_q;
      commit  = 1'b0;
      if ({seg_in, an_in} != in_q) begin
         cnt_d   = '0;
         state_d = SETTLE;
      end else begin
         if (cnt_q != CW'(STABLE_CYCLES))
            cnt_d = cnt_q + 1'b1;
         if (state_q == SETTLE && cnt_q == CW'(STABLE_CYCLES - 1)) begin
            commit  = 1'b1;
            state_d = HOLD;
         end
      end
   end

   seg_pattern_lookup u_lookup (
      .seg   (in_q[14:8]),
      .code  (code),
      .hit   (hit),
      .blank (blank)
   );

   assign an_low  = ~in_q[7:0];
   assign any_low = |an_low;
   assign one_hot = any_low && ((an_low & (an_low - 8'd1)) == 8'd0);

   always_comb begin
      pos = '0;
      for (int i = 0; i < 8; i++)
         if (an_low[i]) pos = 3'(i);
   end

`ifdef SEG_STALE_EN
   localparam int AW = $clog2(STALE_CYCLES + 1);
   logic [AW-1:0] age_q [8];
   logic [AW-1:0] age_d [8];
`endif

   // outputs / digit storage
   always_comb begin
      digits_d      = digits_q;
      valid_d       = valid_q;
      dp_d          = dp_q;
      upd_d         = 1'b0;
      upd_pos_d     = upd_pos_q;
      err_pattern_d = 1'b0;
      err_multi_d   = 1'b0;
      if (commit && any_low) begin
         if (!one_hot) begin
            err_multi_d = 1'b1;
         end else begin
            upd_pos_d = pos;
            if (hit) begin
               digits_d[pos] = code;
               valid_d[pos]  = 1'b1;
               dp_d[pos]     = ~in_q[15];
               upd_d         = 1'b1;
            end else if (blank) begin
               valid_d[pos] = 1'b0;
               dp_d[pos]    = ~in_q[15];
               upd_d        = 1'b1;
            end else begin
               valid_d[pos]  = 1'b0;
               err_pattern_d = 1'b1;
            end
         end
      end
`ifdef SEG_STALE_EN
      for (int i = 0; i < 8; i++) begin
         age_d[i] = age_q[i];
         if (commit && one_hot && pos == 3'(i))
            age_d[i] = '0;
         else if (age_q[i] != AW'(STALE_CYCLES))
            age_d[i] = age_q[i] + 1'b1;
         if (age_d[i] == AW'(STALE_CYCLES))
            valid_d[i] = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         digits_q      <= '0;
         valid_q       <= '0;
         dp_q          <= '0;
         upd_q         <= 1'b0;
         upd_pos_q     <= '0;
         err_pattern_q <= 1'b0;
         err_multi_q   <= 1'b0;
`ifdef SEG_STALE_EN
         for (int i = 0; i < 8; i++) age_q[i] <= '0;
`endif
      end else begin
         digits_q      <= digits_d;
         valid_q       <= valid_d;
         dp_q          <= dp_d;
         upd_q         <= upd_d;
         upd_pos_q     <= upd_pos_d;
         err_pattern_q <= err_pattern_d;
         err_multi_q   <= err_multi_d;
`ifdef SEG_STALE_EN
         for (int i = 0; i < 8; i++) age_q[i] <= age_d[i];
`endif
      end
   end

   assign digits       = digits_q;
   assign dig_valid    = valid_q;
   assign dp           = dp_q;
   assign upd          = upd_q;
   assign upd_pos      = upd_pos_q;
   assign err_pattern  = err_pattern_q;
   assign err_multi_an = err_multi_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed scenarios followed by random scan
// traffic, every edge compared against a run-length reference model.
module tb_seg_scan_decoder;

   localparam int STABLE = 4;
   localparam int STALE  = 20;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  seg_in, an_in;
   logic [31:0] digits;
   logic [7:0]  dig_valid, dp;
   logic        upd, err_pattern, err_multi_an;
   logic [2:0]  upd_pos;

   always #5 clk = ~clk;

   seg_scan_decoder #(.STABLE_CYCLES(STABLE), .STALE_CYCLES(STALE)) dut (
      .clk          (clk),
      .rst          (rst),
      .seg_in       (seg_in),
      .an_in        (an_in),
      .digits       (digits),
      .dig_valid    (dig_valid),
      .dp           (dp),
      .upd          (upd),
      .upd_pos      (upd_pos),
      .err_pattern  (err_pattern),
      .err_multi_an (err_multi_an)
   );

   int total = 0;
   int bad   = 0;

   logic [6:0] hex_tab [16];

   // reference model state
   logic [15:0] m_last;
   int          m_run;
   int          m_dig [8];
   int          m_age [8];
   logic [7:0]  m_valid, m_dp;
   logic        m_upd, m_errp, m_errm;
   logic [2:0]  m_pos;
   int          upd_cnt, errp_cnt, errm_cnt;

   function automatic int find_hex(input logic [6:0] p);
      for (int i = 0; i < 16; i++)
         if (hex_tab[i] == p) return i;
      return -1;
   endfunction

   function automatic int zeros8(input logic [7:0] a);
      int n = 0;
      for (int i = 0; i < 8; i++) if (!a[i]) n++;
      return n;
   endfunction

   function automatic logic [31:0] m_digits();
      logic [31:0] v = '0;
      for (int i = 0; i < 8; i++) v[4*i +: 4] = m_dig[i][3:0];
      return v;
   endfunction

   task automatic model_edge(input logic r, input logic [15:0] s);
      int cpos = -1;
      m_upd = 0; m_errp = 0; m_errm = 0;
      if (r) begin
         m_last = 16'hFFFF; m_run = 1;
         for (int i = 0; i < 8; i++) begin m_dig[i] = 0; m_age[i] = 0; end
         m_valid = '0; m_dp = '0; m_pos = '0;
         return;
      end
      if (s == m_last) m_run++;
      else begin m_run = 1; m_last = s; end
      if (m_run == STABLE + 1) begin
         if (zeros8(s[7:0]) > 1) m_errm = 1;
         else if (zeros8(s[7:0]) == 1) begin
            for (int i = 0; i < 8; i++) if (!s[i]) cpos = i;
            m_pos = 3'(cpos);
            if (find_hex(s[14:8]) >= 0) begin
               m_dig[cpos] = find_hex(s[14:8]);
               m_valid[cpos] = 1; m_dp[cpos] = ~s[15]; m_upd = 1;
            end else if (s[14:8] == 7'h7F) begin
               m_valid[cpos] = 0; m_dp[cpos] = ~s[15]; m_upd = 1;
            end else begin
               m_valid[cpos] = 0; m_errp = 1;
            end
         end
      end
`ifdef SEG_STALE_EN
      for (int i = 0; i < 8; i++) begin
         if (i == cpos) m_age[i] = 0;
         else if (m_age[i] < STALE) m_age[i]++;
         if (m_age[i] == STALE) m_valid[i] = 0;
      end
`endif
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      check("digits", digits, m_digits());
      check("dig_valid", 32'(dig_valid), 32'(m_valid));
      check("dp", 32'(dp), 32'(m_dp));
      check("upd", 32'(upd), 32'(m_upd));
      check("upd_pos", 32'(upd_pos), 32'(m_pos));
      check("err_pattern", 32'(err_pattern), 32'(m_errp));
      check("err_multi_an", 32'(err_multi_an), 32'(m_errm));
   endtask

   task automatic tick(input logic [7:0] s, input logic [7:0] a, input logic r);
      seg_in = s; an_in = a; rst = r;
      @(posedge clk);
      model_edge(r, {s, a});
      if (m_upd) upd_cnt++;
      if (m_errp) errp_cnt++;
      if (m_errm) errm_cnt++;
      #1 check_all();
   endtask

   task automatic hold(input logic [7:0] s, input logic [7:0] a, input int n);
      for (int i = 0; i < n; i++) tick(s, a, 1'b0);
   endtask

   task automatic do_reset();
      tick(8'hFF, 8'hFF, 1'b1);
      tick(8'hFF, 8'hFF, 1'b1);
      upd_cnt = 0; errp_cnt = 0; errm_cnt = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

   initial begin
      logic [7:0] s, a;
      logic [6:0] p;
      int kind, hold_len;
      hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      seg_in = 8'hFF; an_in = 8'hFF; rst = 1'b1;
      upd_cnt = 0; errp_cnt = 0; errm_cnt = 0;

      // reset state
      do_reset();
      check("reset_digits", digits, 32'h0);
      check("reset_valid", 32'(dig_valid), 32'h0);

      // 1: single digit, commit exactly on the 5th edge
      for (int i = 1; i <= 10; i++) begin
         tick(8'hC0, 8'hFE, 1'b0);
         check("t1_upd_edge", 32'(upd), (i == STABLE + 1) ? 32'd1 : 32'd0);
      end
      check("t1_upd_count", upd_cnt, 1);
      check("t1_digit0", 32'(digits[3:0]), 32'h0);
      check("t1_valid", 32'(dig_valid), 32'h01);

      // 2: full scan of 1..8
      upd_cnt = 0;
      for (int d = 0; d < 8; d++) begin
         a = ~(8'h01 << d);
         hold({1'b1, hex_tab[d + 1]}, a, 8);
      end
      check("t2_digits", digits, 32'h87654321);
      check("t2_valid", 32'(dig_valid), 32'hFF);
      check("t2_upd_count", upd_cnt, 8);

      // 3: short glitch is filtered
      do_reset();
      hold(8'hA4, 8'hFE, 3);
      hold(8'hFF, 8'hFF, 6);
      check("t3_upd_count", upd_cnt, 0);
      check("t3_valid", 32'(dig_valid), 32'h0);

      // 4: multi-anode then unknown pattern
      hold(8'hA4, 8'hFC, 8);
      check("t4_multi_count", errm_cnt, 1);
      check("t4_valid_unch", 32'(dig_valid), 32'h0);
      hold(8'hA4, 8'hFE, 8);
      check("t4_valid0_set", 32'(dig_valid[0]), 32'h1);
      hold(8'hBF, 8'hFE, 8);
      check("t4_pat_count", errp_cnt, 1);
      check("t4_valid0_clr", 32'(dig_valid[0]), 32'h0);
      check("t4_digit0_kept", 32'(digits[3:0]), 32'h2);

      // 5: digit 3 with dp, then blank
      hold(8'h00, 8'hF7, 8);
      check("t5_digit3", 32'(digits[15:12]), 32'h8);
      check("t5_dp", 32'(dp), 32'h08);
      upd_cnt = 0; errp_cnt = 0;
      hold(8'hFF, 8'hF7, 8);
      check("t5_blank_valid3", 32'(dig_valid[3]), 32'h0);
      check("t5_blank_dp3", 32'(dp[3]), 32'h0);
      check("t5_blank_upd", upd_cnt, 1);
      check("t5_blank_noerr", errp_cnt, 0);

      // 6: reset mid-settle, held input commits 5 edges after release
      hold(8'hF9, 8'hFD, 3);
      tick(8'hF9, 8'hFD, 1'b1);
      check("t6_reset_digits", digits, 32'h0);
      check("t6_reset_valid", 32'(dig_valid), 32'h0);
      for (int i = 1; i <= 8; i++) begin
         tick(8'hF9, 8'hFD, 1'b0);
         check("t6_upd_edge", 32'(upd), (i == STABLE + 1) ? 32'd1 : 32'd0);
      end
      check("t6_digit1", 32'(digits[7:4]), 32'h1);

`ifdef SEG_STALE_EN
      hold(8'hC0, 8'hFE, 5);
      check("stale_set", 32'(dig_valid[0]), 32'h1);
      hold(8'hFF, 8'hFF, STALE + 3);
      check("stale_clr", 32'(dig_valid[0]), 32'h0);
      check("stale_digit_kept", 32'(digits[3:0]), 32'h0);
`endif

      // random scan traffic
      do_reset();
      for (int n = 0; n < 200; n++) begin
         kind = $urandom_range(0, 9);
         a = ~(8'h01 << $urandom_range(0, 7));
         s = {1'($urandom_range(0, 1)), 7'h7F};
         if (kind <= 5) s[6:0] = hex_tab[$urandom_range(0, 15)];
         else if (kind == 7) begin
            p = 7'($urandom);
            while (find_hex(p) >= 0 || p == 7'h7F) p = 7'($urandom);
            s[6:0] = p;
         end else if (kind == 8) begin
            s[6:0] = hex_tab[$urandom_range(0, 15)];
            a = 8'($urandom);
            while (zeros8(a) < 2) a = 8'($urandom);
         end else if (kind == 9) a = 8'hFF;
         hold_len = $urandom_range(1, 8);
         hold(s, a, hold_len);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
